// File: rtl/sprite_line_scheduler_if.sv
// Bus bundle for sprite_line_scheduler: line/frame requests, sprite table in, committed slots out.
// Default geometry macros are provided here when the build does not define them.
`ifndef WIDTH_LOG2
`define WIDTH_LOG2 9
`endif
`ifndef HEIGHT_LOG2
`define HEIGHT_LOG2 8
`endif
`ifndef TILE_SIZE_LOG2
`define TILE_SIZE_LOG2 5
`endif
`ifndef TILE_SIZE
`define TILE_SIZE 20
`endif
`ifndef HEIGHT_MAX
`define HEIGHT_MAX 255
`endif

interface sprite_line_scheduler_if #(
    parameter int unsigned SPRITES = 5,
    parameter int unsigned SLOTS   = 4
);
    logic                                line_start;
    logic [`HEIGHT_LOG2-1:0]             line_y;
    logic                                frame_start;
    logic [SPRITES-1:0]                  sprite_en;
    logic [SPRITES*`WIDTH_LOG2-1:0]      sprite_x;
    logic [SPRITES*`HEIGHT_LOG2-1:0]     sprite_y;
    logic                                busy;
    logic                                done;
    logic [SLOTS-1:0]                    slot_valid;
    logic [SLOTS*3-1:0]                  slot_id;
    logic [SLOTS*`WIDTH_LOG2-1:0]        slot_x;
    logic [SLOTS*`TILE_SIZE_LOG2-1:0]    slot_row;
    logic                                overflow;

    modport master (
        output line_start, line_y, frame_start, sprite_en, sprite_x, sprite_y,
        input  busy, done, slot_valid, slot_id, slot_x, slot_row, overflow
    );

    modport slave (
        input  line_start, line_y, frame_start, sprite_en, sprite_x, sprite_y,
        output busy, done, slot_valid, slot_id, slot_x, slot_row, overflow
    );
endinterface

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite selector: scans one sprite per cycle and commits up to SLOTS hits atomically.
// Optional macro SPRITE_FLICKER_EN rotates the scan start index once per frame_start.
`ifndef WIDTH_LOG2
`define WIDTH_LOG2 9
`endif
`ifndef HEIGHT_LOG2
`define HEIGHT_LOG2 8
`endif
`ifndef TILE_SIZE_LOG2
`define TILE_SIZE_LOG2 5
`endif
`ifndef TILE_SIZE
`define TILE_SIZE 20
`endif

module sprite_line_scheduler #(
    parameter int unsigned SPRITES = 5,
    parameter int unsigned SLOTS   = 4
) (
    input logic                   clk,
    input logic                   reset,
    sprite_line_scheduler_if.slave bus
);
    localparam int unsigned WW = `WIDTH_LOG2;
    localparam int unsigned HW = `HEIGHT_LOG2;
    localparam int unsigned RW = `TILE_SIZE_LOG2;
    localparam int unsigned IW = (SPRITES > 1) ? $clog2(SPRITES) : 1;
    localparam int unsigned FW = $clog2(SLOTS + 1);
    localparam logic [HW:0] TILE_EXT = (HW+1)'(`TILE_SIZE);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t              state;
    logic [HW-1:0]       lat_y;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       cnt;
    logic [FW-1:0]       fill;
    logic [SLOTS-1:0]    w_valid;
    logic [SLOTS*3-1:0]  w_id;
    logic [SLOTS*WW-1:0] w_x;
    logic [SLOTS*RW-1:0] w_row;
    logic                w_ovf;

    logic [IW-1:0]       start_c;
    logic [HW-1:0]       cur_y_c;
    logic [WW-1:0]       cur_x_c;
    logic                hit_c;
    logic [RW-1:0]       row_c;

`ifdef SPRITE_FLICKER_EN
    logic [IW-1:0] rot;
    assign start_c = rot;
`else
    logic unused_c;
    assign start_c  = '0;
    assign unused_c = bus.frame_start;
`endif

    // Hit test for the sprite under evaluation; the sum is one bit wider so it cannot wrap.
    always_comb begin
        cur_y_c = bus.sprite_y[int'(idx)*HW +: HW];
        cur_x_c = bus.sprite_x[int'(idx)*WW +: WW];
        hit_c   = bus.sprite_en[idx]
                  && ({1'b0, lat_y} >= {1'b0, cur_y_c})
                  && ({1'b0, lat_y} <  ({1'b0, cur_y_c} + TILE_EXT));
        row_c   = RW'(lat_y - cur_y_c);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            lat_y          <= '0;
            idx            <= '0;
            cnt            <= '0;
            fill           <= '0;
            w_valid        <= '0;
            w_id           <= '0;
            w_x            <= '0;
            w_row          <= '0;
            w_ovf          <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.slot_valid <= '0;
            bus.slot_id    <= '0;
            bus.slot_x     <= '0;
            bus.slot_row   <= '0;
            bus.overflow   <= 1'b0;
`ifdef SPRITE_FLICKER_EN
            rot            <= '0;
`endif
        end else begin
            bus.done <= 1'b0;
`ifdef SPRITE_FLICKER_EN
            // Rotation advances after this cycle, so a coincident line_start sees the old index.
            if (bus.frame_start)
                rot <= (rot == IW'(SPRITES-1)) ? '0 : rot + IW'(1);
`endif
            case (state)
                IDLE: begin
                    if (bus.line_start) begin
                        lat_y    <= bus.line_y;
                        idx      <= start_c;
                        cnt      <= '0;
                        fill     <= '0;
                        w_valid  <= '0;
                        w_id     <= '0;
                        w_x      <= '0;
                        w_row    <= '0;
                        w_ovf    <= 1'b0;
                        bus.busy <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit_c) begin
                        if (fill < FW'(SLOTS)) begin
                            w_valid                    <= w_valid | (SLOTS'(1) << fill);
                            w_id[int'(fill)*3 +: 3]    <= 3'(idx);
                            w_x[int'(fill)*WW +: WW]   <= cur_x_c;
                            w_row[int'(fill)*RW +: RW] <= row_c;
                            fill                       <= fill + FW'(1);
                        end else begin
                            w_ovf <= 1'b1;
                        end
                    end
                    idx <= (idx == IW'(SPRITES-1)) ? '0 : idx + IW'(1);
                    cnt <= cnt + IW'(1);
                    if (cnt == IW'(SPRITES-1))
                        state <= COMMIT;
                end
                COMMIT: begin
                    bus.slot_valid <= w_valid;
                    bus.slot_id    <= w_id;
                    bus.slot_x     <= w_x;
                    bus.slot_row   <= w_row;
                    bus.overflow   <= w_ovf;
                    bus.done       <= 1'b1;
                    bus.busy       <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
